seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Iterative radix-2 restoring divider: the subtract-based inverse of the datapath's block-CLA adder.
//  Takes WIDTH-bit dividend/divisor; produces quotient and remainder after WIDTH iterations.
//  Sits beside the ALU as a multi-cycle execution unit, driven by the control FSM via start/ready/done.
// PARAMETERS
//  WIDTH           8   operand, quotient and remainder width; must be >= 2
//  BITS_PER_BLOCK  4   carry-lookahead block size of the internal subtractor; must divide WIDTH+1 padded to multiple
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  start      in   1      request; accepted only when ready=1
//  dividend   in   WIDTH  sampled on accepted start
//  divisor    in   WIDTH  sampled on accepted start
//  ready      out  1      1 in IDLE only
//  done       out  1      one-cycle pulse; quotient/remainder valid from this cycle
//  quotient   out  WIDTH  held until next accepted start
//  remainder  out  WIDTH  held until next accepted start
//  div_by_zero out 1      valid with done; held with results
// BEHAVIOUR
//  - One clock; reset synchronous, active-high: state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0.
//  - States: IDLE -> RUN (start & divisor!=0) | DONE (start & divisor==0); RUN -> DONE after WIDTH iterations; DONE -> IDLE.
//  - Accept edge = cycle 0; RUN occupies cycles 1..WIDTH; done=1 in cycle WIDTH+1; ready=1 again cycle WIDTH+2.
//  - Per RUN cycle: partial = {rem, dvd_msb}; diff = partial - {0,divisor} (WIDTH+1 bits, CLA subtract, CI=1);
//    no borrow -> rem=diff, qbit=1; else rem=partial, qbit=0; dividend shifts left, qbit enters LSB.
//  - Iteration counter counts WIDTH-1 down to 0; RUN exits when counter==0 on that edge.
//  - Divide by zero: skip RUN; done at cycle 1; quotient=all ones, remainder=dividend, div_by_zero=1.
//  - start while not ready: ignored, no state change, operands not sampled.
//  - start held high across DONE: re-accepted only in following IDLE cycle.
//  - rst mid-operation: aborts, all outputs to reset values next edge, no done pulse.
//  - quotient/remainder registers update only in DONE cycle; unchanged during RUN.
// CONFIGURATION
//  DIVIDER_SIGNED_EN defined: adds input port signed_op (1); when 1 at accept, operands two's-complement;
//    magnitudes divided; quotient negated if signs differ; remainder takes dividend sign (truncate toward zero);
//    sign fix-up adds one cycle: done at WIDTH+2; MIN/-1 -> quotient=MIN, remainder=0; /0 -> q=all ones, r=dividend.
//  Not defined: no signed_op port, unsigned only, timing as above.
// STRUCTURE
//  Shared package div_pkg: state encoding localparams (IDLE, RUN, FIXUP, DONE), counter width function clog2.
//  One sub-module: cla_subtractor (WIDTH+1 bits, block CLA, A - B via ~B with CI=1, outputs diff and borrow).
//  Top holds FSM, counter, shift registers, output registers.
// TESTING
//  1. WIDTH=8, 200/7 -> quotient=28, remainder=4, div_by_zero=0, done exactly in cycle 9.
//  2. 5/0 -> quotient=0xFF, remainder=5, div_by_zero=1, done in cycle 1, ready back in cycle 2.
//  3. 255/1 -> 255 r 0; 3/10 -> 0 r 3; 0/9 -> 0 r 0; results held until next start.
//  4. start pulsed at cycles 3 and 8 during 200/7 -> ignored; results still 28 r 4 at cycle 9.
//  5. rst asserted at cycle 4 of an operation -> outputs zero, ready=1 next cycle, no done pulse.
//  6. DIVIDER_SIGNED_EN, signed_op=1: -7/2 -> q=0xFD, r=0xFF; -128/-1 -> q=0x80, r=0; done in cycle 10.

Source files
------------

// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Brief    : Shared state encoding and helper function for seq_divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Smallest n with 2**n >= value; sizes the iteration counter.
   function automatic int clog2(input int value);
      int n;
      n = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) n = i + 1;
      end
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cla_subtractor.sv
// ============================================================================
// Module   : cla_subtractor
// Brief    : Block carry-lookahead A - B (A + ~B + 1); borrow = no carry out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_subtractor
   import div_pkg::*;
#(
   parameter int WIDTH          = 9,
   parameter int BITS_PER_BLOCK = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow
);

   localparam int NBLK = (WIDTH + BITS_PER_BLOCK - 1) / BITS_PER_BLOCK;
   localparam int NPAD = NBLK * BITS_PER_BLOCK;

   logic [NPAD-1:0] w_a;
   logic [NPAD-1:0] w_bn;
   logic [NPAD-1:0] w_g;
   logic [NPAD-1:0] w_p;
   logic [NPAD-1:0] w_sum;
   logic [NPAD:0]   w_c;
   logic            w_unused_pad;

   // Pad bits have g=p=0, so they never disturb the real carry chain.
   assign w_a  = NPAD'(i_a);
   assign w_bn = NPAD'(~i_b);
   assign w_g  = w_a & w_bn;
   assign w_p  = w_a ^ w_bn;

   always_comb begin
      logic blk_ci;
      logic grp_g;
      logic grp_p;
      w_c    = '0;
      blk_ci = 1'b1;
      grp_g  = 1'b0;
      grp_p  = 1'b1;
      for (int bk = 0; bk < NBLK; bk++) begin
         grp_g = 1'b0;
         grp_p = 1'b1;
         for (int j = 0; j < BITS_PER_BLOCK; j++) begin
            w_c[bk*BITS_PER_BLOCK+j] = grp_g | (grp_p & blk_ci);
            grp_g = w_g[bk*BITS_PER_BLOCK+j] | (w_p[bk*BITS_PER_BLOCK+j] & grp_g);
            grp_p = grp_p & w_p[bk*BITS_PER_BLOCK+j];
         end
         blk_ci = grp_g | (grp_p & blk_ci);
      end
      w_c[NPAD] = blk_ci;
   end

   assign w_sum        = w_p ^ w_c[NPAD-1:0];
   assign o_diff       = w_sum[WIDTH-1:0];
   assign o_borrow     = ~w_c[WIDTH];
   assign w_unused_pad = ^{w_sum, w_c};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module   : seq_divider
// Brief    : Iterative radix-2 restoring divider, one quotient bit per cycle.
//            Macro DIVIDER_SIGNED_EN adds signed_op and a sign fix-up cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
`ifdef DIVIDER_SIGNED_EN
   ,
   input  logic             signed_op
`endif
);

   localparam int CNT_W = clog2(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dsr;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_remo;
   logic             r_dz;
   logic             r_done;

   logic [WIDTH:0]   w_partial;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_sel;
   logic             w_borrow;
   logic             w_qbit;
   logic             w_unused_msb;
   logic [WIDTH-1:0] w_rem_nx;
   logic [WIDTH-1:0] w_quo_nx;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dsr_mag;
   logic             w_fix;
   logic             w_neg_q;
   logic             w_neg_r;

`ifdef DIVIDER_SIGNED_EN
   logic r_sgn;
   logic r_neg_q;
   logic r_neg_r;
   logic w_sa;
   logic w_sb;

   assign w_sa      = signed_op & dividend[WIDTH-1];
   assign w_sb      = signed_op & divisor[WIDTH-1];
   assign w_dvd_mag = w_sa ? -dividend : dividend;
   assign w_dsr_mag = w_sb ? -divisor : divisor;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sgn   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_sgn   <= signed_op;
         r_neg_q <= w_sa ^ w_sb;
         r_neg_r <= w_sa;
      end
   end

   assign w_fix   = r_sgn;
   assign w_neg_q = r_neg_q;
   assign w_neg_r = r_neg_r;
`else
   assign w_dvd_mag = dividend;
   assign w_dsr_mag = divisor;
   assign w_fix     = 1'b0;
   assign w_neg_q   = 1'b0;
   assign w_neg_r   = 1'b0;
`endif

   // Next dividend bit joins the partial remainder; keep it only if divisor fits.
   assign w_partial = {r_rem, r_dvd[WIDTH-1]};

   cla_subtractor #(
      .WIDTH          (WIDTH + 1),
      .BITS_PER_BLOCK (BITS_PER_BLOCK)
   ) u_sub (
      .i_a      (w_partial),
      .i_b      ({1'b0, r_dsr}),
      .o_diff   (w_diff),
      .o_borrow (w_borrow)
   );

   assign w_qbit       = ~w_borrow;
   assign w_sel        = w_borrow ? w_partial : w_diff;
   assign w_rem_nx     = w_sel[WIDTH-1:0];
   assign w_unused_msb = w_sel[WIDTH];
   assign w_quo_nx     = {r_dvd[WIDTH-2:0], w_qbit};

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = (divisor == '0) ? DONE : RUN;
         RUN:     if (r_cnt == '0) w_next = w_fix ? FIXUP : DONE;
         FIXUP:   w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_dvd  <= '0;
         r_rem  <= '0;
         r_dsr  <= '0;
         r_quo  <= '0;
         r_remo <= '0;
         r_dz   <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_dvd <= w_dvd_mag;
                  r_dsr <= w_dsr_mag;
                  r_rem <= '0;
                  r_cnt <= CNT_W'(WIDTH - 1);
                  if (divisor == '0) begin
                     r_quo  <= '1;
                     r_remo <= dividend;
                     r_dz   <= 1'b1;
                     r_done <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_rem <= w_rem_nx;
               r_dvd <= w_quo_nx;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == '0 && !w_fix) begin
                  r_quo  <= w_quo_nx;
                  r_remo <= w_rem_nx;
                  r_dz   <= 1'b0;
                  r_done <= 1'b1;
               end
            end
            FIXUP: begin
               r_quo  <= w_neg_q ? -r_dvd : r_dvd;
               r_remo <= w_neg_r ? -r_rem : r_rem;
               r_dz   <= 1'b0;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ready       = (r_state == IDLE);
   assign done        = r_done;
   assign quotient    = r_quo;
   assign remainder   = r_remo;
   assign div_by_zero = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module   : tb_seq_divider
// Brief    : Directed and random checks of seq_divider against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         ready;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
`ifdef DIVIDER_SIGNED_EN
   logic         signed_op;
`endif

   int checks = 0;
   int errors = 0;

   // Results the outputs must currently hold.
   logic [W-1:0] pq  = '0;
   logic [W-1:0] pr  = '0;
   logic         pdz = 1'b0;

   always #5 clk = ~clk;

   seq_divider #(
      .WIDTH          (W),
      .BITS_PER_BLOCK (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
`ifdef DIVIDER_SIGNED_EN
      ,
      .signed_op   (signed_op)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Truncating division on integers; result cycle is when done must appear.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int cyc);
      int ia;
      int ib;
      if (b == '0) begin
         q = '1; r = a; dz = 1'b1; cyc = 1;
      end else begin
         dz = 1'b0;
         if (sg) begin
            ia = int'($signed(a)); ib = int'($signed(b)); cyc = W + 2;
         end else begin
            ia = int'(a); ib = int'(b); cyc = W + 1;
         end
         q = W'(ia / ib);
         r = W'(ia % ib);
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         input bit pulse, input string tag);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         edz;
      int           ecyc;
      int           n;
      model(a, b, sg, eq, er, edz, ecyc);
      @(negedge clk);
      check({tag, "/ready_before"}, 32'(ready), 32'(1));
      dividend = a;
      divisor  = b;
      start    = 1'b1;
`ifdef DIVIDER_SIGNED_EN
      signed_op = sg;
`endif
      @(negedge clk);
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      n = 1;
      if (ecyc > 1) check({tag, "/q_held_in_run"}, 32'(quotient), 32'(pq));
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
         if (pulse && (n == 3 || n == 8)) begin
            start    = 1'b1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      check({tag, "/done_cycle"}, 32'(n), 32'(ecyc));
      check({tag, "/quotient"}, 32'(quotient), 32'(eq));
      check({tag, "/remainder"}, 32'(remainder), 32'(er));
      check({tag, "/div_by_zero"}, 32'(div_by_zero), 32'(edz));
      pq = eq; pr = er; pdz = edz;
      @(negedge clk);
      check({tag, "/done_pulse_end"}, 32'(done), 32'(0));
      check({tag, "/ready_after"}, 32'(ready), 32'(1));
      check({tag, "/q_held_after"}, 32'(quotient), 32'(pq));
   endtask

   initial begin : stim
      int seen;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
`ifdef DIVIDER_SIGNED_EN
      signed_op = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset/ready", 32'(ready), 32'(1));
      check("reset/done", 32'(done), 32'(0));
      check("reset/quotient", 32'(quotient), 32'(0));
      check("reset/remainder", 32'(remainder), 32'(0));
      check("reset/div_by_zero", 32'(div_by_zero), 32'(0));

      run_op(8'd200, 8'd7, 1'b0, 1'b1, "t200_7_pulsed");
      run_op(8'd5, 8'd0, 1'b0, 1'b0, "t5_0");
      run_op(8'd255, 8'd1, 1'b0, 1'b0, "t255_1");
      run_op(8'd3, 8'd10, 1'b0, 1'b0, "t3_10");
      run_op(8'd0, 8'd9, 1'b0, 1'b0, "t0_9");

      // start held high through DONE is re-accepted only once back in IDLE
      @(negedge clk);
      dividend = 8'd5; divisor = 8'd0; start = 1'b1;
      @(negedge clk);
      check("held/done_c1", 32'(done), 32'(1));
      @(negedge clk);
      check("held/done_c2", 32'(done), 32'(0));
      check("held/ready_c2", 32'(ready), 32'(1));
      @(negedge clk);
      check("held/done_c3", 32'(done), 32'(1));
      start = 1'b0;
      pq = 8'hFF; pr = 8'd5; pdz = 1'b1;
      @(negedge clk);
      check("held/ready_c4", 32'(ready), 32'(1));

      // reset in the middle of an operation
      run_op(8'd200, 8'd7, 1'b0, 1'b0, "pre_reset");
      @(negedge clk);
      dividend = 8'd99; divisor = 8'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset/quotient", 32'(quotient), 32'(0));
      check("midreset/remainder", 32'(remainder), 32'(0));
      check("midreset/div_by_zero", 32'(div_by_zero), 32'(0));
      check("midreset/ready", 32'(ready), 32'(1));
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      check("midreset/no_done", 32'(seen), 32'(0));
      pq = '0; pr = '0; pdz = 1'b0;

`ifdef DIVIDER_SIGNED_EN
      run_op(8'hF9, 8'd2, 1'b1, 1'b0, "s_m7_2");
      run_op(8'h80, 8'hFF, 1'b1, 1'b0, "s_min_m1");
      run_op(8'hF9, 8'd0, 1'b1, 1'b0, "s_m7_0");
`endif

      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = (i % 8 == 0) ? '0 : (i % 8 == 1) ? W'(1) : W'($urandom);
`ifdef DIVIDER_SIGNED_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         run_op(ra, rb, rs, (i % 5 == 0), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
